amo_rmw_sequencer: RTL and testbench
====================================

Name: amo_rmw_sequencer

Overview:
Sequences RISC-V A-extension operations (LR, SC and read-modify-write AMOs) for the load/store unit, one at a time, over a single-outstanding memory port. It owns the LR/SC reservation register: set on LR, cleared on SC, on snooped conflicting stores, on flush, or on timeout. It sits behind the store queue and receives AMOs only once they are non-speculative, at retire. Results return on a held writeback handshake.

Parameters:
RESERVATION_TIMEOUT, 64, cycles after an LR before the reservation self-expires (must be ≥2).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  AMO request offered
req_ready  out  1  high only in IDLE
req_addr  in  32  target address; bits [1:0] ignored (alignment checked upstream)
req_rs2  in  32  rs2 operand (SC store data / AMO operand)
req_amo  in  $bits(amo_details_t)  is_lr/is_sc/is_rmw/acquire/release/op
req_wb  in  1  rd is written (rd≠x0)
req_id  in  id_t  instruction id
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_load  out  1  read request
mem_req_store  out  1  write request
mem_req_addr  out  32  {req_addr[31:2],2'b00}
mem_req_data  out  32  store data
mem_req_be  out  4  always 4'hF
mem_rsp_valid  in  1  load data valid
mem_rsp_data  in  32  load data
snoop_valid  in  1  another agent/hart store observed
snoop_addr  in  32  snooped store address
flush  in  1  gc memq_flush
wb_valid  out  1  result pending
wb_ack  in  1  writeback consumed
wb_id  out  id_t  id of result
wb_data  out  32  result
busy  out  1  state≠IDLE
reservation_valid  out  1  debug/trace view of reservation

Behaviour:
- Reset: state=IDLE; all outputs 0 except req_ready=1; reservation invalid; timeout counter 0.
- FSM states: IDLE, LOAD_REQ, LOAD_WAIT, ALU, STORE_REQ, WB.
- IDLE: on req_valid, latch addr/rs2/amo/id/wb.
  - LR or RMW → LOAD_REQ.
  - SC with reservation_valid && res_addr==addr[31:2] && no same-cycle snoop match → STORE_REQ, data=rs2, result=0.
  - SC otherwise → WB with result=1 and no memory access, or IDLE if !req_wb.
  - Every accepted SC clears the reservation at the end of the accept cycle.
- LOAD_REQ: mem_req_valid=1, load=1. Advance to LOAD_WAIT on mem_req_ready. The request is held stable until accepted.
- LOAD_WAIT: on mem_rsp_valid, capture old value into result. LR → WB and sets the reservation. RMW → ALU.
- ALU: one cycle. The amo_alu sub-module computes f(old,rs2) into the store data register; the next state is STORE_REQ.
  - op encodings: 00000 ADD, 00001 SWAP, 00100 XOR, 01000 OR, 01100 AND, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU.
  - MIN/MAX use a signed compare; MINU/MAXU use an unsigned compare.
  - ADD wraps modulo 2^32.
- STORE_REQ: mem_req_valid=1, store=1, be=F. On mem_req_ready → WB if req_wb, else IDLE.
- WB: wb_valid=1 with wb_id and wb_data held until wb_ack, then IDLE. wb_ack while wb_valid=0 is ignored.
- Latency, LR with ready=1 and response the cycle after acceptance: accept at cycle 0, mem_req at cycle 1, rsp at cycle 2, wb_valid at cycle 3. An RMW adds 2 cycles (ALU plus STORE_REQ).
- Reservation handling:
  - An LR response sets res_valid=1, res_addr=addr[31:2] and counter=0, unless a snoop to the same word arrives in the same cycle; in that case the reservation stays invalid.
  - The counter increments while res_valid. At RESERVATION_TIMEOUT-1, res_valid clears.
  - A snoop matching res_addr clears the reservation. flush clears it at any time.
  - A new LR replaces the reservation.
- Flush does not abort an in-flight op, because AMOs are committed. The FSM completes normally.
- rst mid-operation returns to IDLE immediately. Any memory response still in flight after rst is the memory side's responsibility.
- acquire/release bits are passed through only; ordering is enforced upstream by sq drain.

Decomposition:
- The codebase's shared types package (where amo_details_t, amo_alu_inputs_t and id_t live) gains:
  - amo_seq_state_t enum;
  - AMO op localparams (AMO_ADD…AMO_MAXU).
- Sub-module: amo_alu. It is combinational, takes amo_alu_inputs_t and outputs a 32-bit result, and can be reused by the dcache.

Test Plan:
1. LR 0x1000 (mem returns 0xDEAD_BEEF), ready=1 → mem load at cycle 1, wb_data=0xDEADBEEF at cycle 3, reservation_valid=1.
2. Scenario 1 then SC 0x1000 rs2=5 → store data=5 at 0x1000, wb_data=0. A second SC → no memory access, wb_data=1.
3. LR 0x2000; snoop 0x2004 (no clear), then snoop 0x2000; SC 0x2000 → SC fails, wb_data=1, no store.
4. AMOMIN old=0xFFFF_FFFE, rs2=3 → store 0xFFFFFFFE, wb=0xFFFFFFFE. AMOMINU with the same operands → store 3. AMOADD 0xFFFFFFFF+2 → store 1.
5. LR, idle for 64 cycles → reservation_valid drops at cycle 64 after the LR response, and a later SC fails. A flush one cycle after LR also fails the SC.
6. AMOSWAP with req_wb=0 and mem_req_ready stalled 5 cycles → request held stable, no wb_valid, return to IDLE. A wb_ack held low for 3 cycles in another op keeps req_ready=0 and wb_data stable.

Source files
------------

// File: rtl/amo_rmw_sequencer_pkg.sv
// amo_rmw_sequencer_pkg: shared AMO types, sequencer states and op encodings
package amo_rmw_sequencer_pkg;
  typedef logic [7:0] id_t;
  typedef struct packed {
    logic       is_lr;
    logic       is_sc;
    logic       is_rmw;
    logic       aq;
    logic       rl;
    logic [4:0] op;
  } amo_details_t;
  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] old;
    logic [31:0] rs2;
  } amo_alu_inputs_t;
  typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_WAIT, ALU, STORE_REQ, WB} amo_seq_state_t;
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;
endpackage

// File: rtl/amo_rmw_sequencer_alu.sv
// amo_alu: combinational read-modify-write function f(old, rs2)
module amo_alu
  import amo_rmw_sequencer_pkg::*;
(
  input  amo_alu_inputs_t ops,
  output logic [31:0]     result
);
  logic lt_s, lt_u;
  assign lt_s = $signed(ops.old) < $signed(ops.rs2);
  assign lt_u = ops.old < ops.rs2;
  // select the AMO function; unknown ops produce zero
  always_comb begin
    result = '0;
    case (ops.op)
      AMO_ADD:  result = ops.old + ops.rs2;
      AMO_SWAP: result = ops.rs2;
      AMO_XOR:  result = ops.old ^ ops.rs2;
      AMO_OR:   result = ops.old | ops.rs2;
      AMO_AND:  result = ops.old & ops.rs2;
      AMO_MIN:  result = lt_s ? ops.old : ops.rs2;
      AMO_MAX:  result = lt_s ? ops.rs2 : ops.old;
      AMO_MINU: result = lt_u ? ops.old : ops.rs2;
      AMO_MAXU: result = lt_u ? ops.rs2 : ops.old;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/amo_rmw_sequencer.sv
// amo_rmw_sequencer: one-at-a-time LR/SC/AMO sequencer owning the LR reservation
module amo_rmw_sequencer
  import amo_rmw_sequencer_pkg::*;
#(
  parameter int RESERVATION_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_rs2,
  input  amo_details_t req_amo,
  input  logic         req_wb,
  input  id_t          req_id,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_load,
  output logic         mem_req_store,
  output logic [31:0]  mem_req_addr,
  output logic [31:0]  mem_req_data,
  output logic [3:0]   mem_req_be,
  input  logic         mem_rsp_valid,
  input  logic [31:0]  mem_rsp_data,
  input  logic         snoop_valid,
  input  logic [31:0]  snoop_addr,
  input  logic         flush,
  output logic         wb_valid,
  input  logic         wb_ack,
  output id_t          wb_id,
  output logic [31:0]  wb_data,
  output logic         busy,
  output logic         reservation_valid
);
  localparam int CW = $clog2(RESERVATION_TIMEOUT);
  amo_seq_state_t state, state_next;
  logic [29:0] addr_q, res_addr;
  logic [31:0] data_q, result_q, alu_out;
  logic [4:0] op_q;
  logic lr_q, wb_q, res_valid;
  id_t id_q;
  logic [CW-1:0] res_cnt;
  logic accept, sc_ok, rsp_done, snoop_req_hit, snoop_res_hit, snoop_cur_hit;
  amo_alu_inputs_t alu_in;
  logic unused;
  assign unused = ^{req_addr[1:0], snoop_addr[1:0], req_amo.is_rmw, req_amo.aq, req_amo.rl};
  assign accept = state == IDLE && req_valid;
  assign snoop_req_hit = snoop_valid && snoop_addr[31:2] == req_addr[31:2];
  assign snoop_res_hit = snoop_valid && snoop_addr[31:2] == res_addr;
  assign snoop_cur_hit = snoop_valid && snoop_addr[31:2] == addr_q;
  assign sc_ok = res_valid && res_addr == req_addr[31:2] && !snoop_req_hit;
  assign rsp_done = state == LOAD_WAIT && mem_rsp_valid;
  assign alu_in = '{op: op_q, old: result_q, rs2: data_q};
  amo_alu u_alu (.ops(alu_in), .result(alu_out));
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign mem_req_valid = state == LOAD_REQ || state == STORE_REQ;
  assign mem_req_load = state == LOAD_REQ;
  assign mem_req_store = state == STORE_REQ;
  assign mem_req_addr = {addr_q, 2'b00};
  assign mem_req_data = data_q;
  assign mem_req_be = {4{mem_req_valid}};
  assign wb_valid = state == WB;
  assign wb_id = id_q;
  assign wb_data = result_q;
  assign reservation_valid = res_valid;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  // next-state: SCs decide success at accept, everything else goes through a load
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (req_valid) state_next = req_amo.is_sc ? (sc_ok ? STORE_REQ : (req_wb ? WB : IDLE)) : LOAD_REQ;
      LOAD_REQ:  if (mem_req_ready) state_next = LOAD_WAIT;
      LOAD_WAIT: if (mem_rsp_valid) state_next = lr_q ? (wb_q ? WB : IDLE) : ALU;
      ALU:       state_next = STORE_REQ;
      STORE_REQ: if (mem_req_ready) state_next = wb_q ? WB : IDLE;
      WB:        if (wb_ack) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end
  // operand latch, load capture (rd result) and ALU store data
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      result_q <= '0;
      op_q <= '0;
      lr_q <= 1'b0;
      wb_q <= 1'b0;
      id_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr[31:2];
        data_q <= req_rs2;
        result_q <= {31'b0, !sc_ok};
        op_q <= req_amo.op;
        lr_q <= req_amo.is_lr;
        wb_q <= req_wb;
        id_q <= req_id;
      end
      if (rsp_done) result_q <= mem_rsp_data;
      if (state == ALU) data_q <= alu_out;
    end
  end
  // reservation: LR response sets, SC/snoop/flush/timeout clear
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_addr <= '0;
      res_cnt <= '0;
    end else if (rsp_done && lr_q) begin
      res_valid <= !flush && !snoop_cur_hit;
      res_addr <= addr_q;
      res_cnt <= '0;
    end else if (flush || snoop_res_hit || (accept && req_amo.is_sc) || (res_valid && res_cnt == CW'(RESERVATION_TIMEOUT - 1))) begin
      res_valid <= 1'b0;
      res_cnt <= '0;
    end else if (res_valid) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_amo_rmw_sequencer.sv
// tb_amo_rmw_sequencer: directed scoreboard bench for the AMO sequencer
module tb_amo_rmw_sequencer;
  import amo_rmw_sequencer_pkg::*;
  typedef struct {logic st; logic [31:0] a; logic [31:0] d;} mexp_t;
  typedef struct {id_t id; logic [31:0] d;} wexp_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_wb = 0;
  logic [31:0] req_addr = 0, req_rs2 = 0;
  amo_details_t req_amo = '0;
  id_t req_id = 0;
  logic mem_req_valid, mem_req_ready, mem_req_load, mem_req_store;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [3:0] mem_req_be;
  logic mem_rsp_valid = 0;
  logic [31:0] mem_rsp_data = 0;
  logic snoop_valid = 0, flush = 0;
  logic [31:0] snoop_addr = 0;
  logic wb_valid, wb_ack, busy, reservation_valid;
  id_t wb_id;
  logic [31:0] wb_data;
  logic mem_ready = 1, ack_en = 1, rsp_next = 0;
  logic [31:0] rsp_val = 0;
  int vectors = 0, miscompares = 0;
  mexp_t mexp[$];
  wexp_t wexp[$];
  assign mem_req_ready = mem_ready;
  assign wb_ack = ack_en;
  always #5 clk = ~clk;
  amo_rmw_sequencer #(.RESERVATION_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rs2(req_rs2), .req_amo(req_amo), .req_wb(req_wb), .req_id(req_id),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_load(mem_req_load),
    .mem_req_store(mem_req_store), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_be(mem_req_be), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .flush(flush), .wb_valid(wb_valid),
    .wb_ack(wb_ack), .wb_id(wb_id), .wb_data(wb_data), .busy(busy), .reservation_valid(reservation_valid));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic bad(input string n);
    vectors++;
    miscompares++;
    $display("FAIL %s", n);
  endtask
  task automatic push_m(input logic st, input logic [31:0] a, input logic [31:0] d);
    mexp.push_back('{st: st, a: a, d: d});
  endtask
  task automatic push_w(input id_t id, input logic [31:0] d);
    wexp.push_back('{id: id, d: d});
  endtask
  // memory responder plus monitor: response one cycle after load acceptance, checks at negedge
  initial forever begin
    mexp_t m;
    wexp_t w;
    @(posedge clk);
    #1;
    mem_rsp_valid = rsp_next;
    mem_rsp_data = rsp_next ? rsp_val : 32'h0;
    rsp_next = 0;
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) begin
      if (mexp.size() == 0) bad("unexpected_mem_req");
      else begin
        m = mexp.pop_front();
        chk("mem_store", {31'b0, mem_req_store}, {31'b0, m.st});
        chk("mem_load", {31'b0, mem_req_load}, {31'b0, !m.st});
        chk("mem_addr", mem_req_addr, m.a);
        chk("mem_be", {28'b0, mem_req_be}, 32'hF);
        if (m.st) chk("mem_data", mem_req_data, m.d);
      end
      if (mem_req_load) rsp_next = 1;
    end
    if (wb_valid && wb_ack) begin
      if (wexp.size() == 0) bad("unexpected_wb");
      else begin
        w = wexp.pop_front();
        chk("wb_id", {24'b0, wb_id}, {24'b0, w.id});
        chk("wb_data", wb_data, w.d);
      end
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input int k, input logic [4:0] op, input logic wb, input id_t id);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) bad("req_ready_timeout");
    req_addr = a;
    req_rs2 = d;
    req_amo = '{is_lr: 1'(k == 0), is_sc: 1'(k == 1), is_rmw: 1'(k == 2), aq: 1'b0, rl: 1'b0, op: op};
    req_wb = wb;
    req_id = id;
    req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((busy || mexp.size() != 0 || wexp.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy || mexp.size() != 0 || wexp.size() != 0) bad("completion_timeout");
  endtask
  task automatic snoop(input logic [31:0] a);
    snoop_addr = a;
    snoop_valid = 1;
    @(posedge clk);
    #1;
    snoop_valid = 0;
  endtask
  logic [4:0] t_op[8] = '{AMO_MIN, AMO_MINU, AMO_ADD, AMO_MAX, AMO_MAXU, AMO_XOR, AMO_OR, AMO_AND};
  logic [31:0] t_old[8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFF00FF00};
  logic [31:0] t_rs2[8] = '{32'd3, 32'd3, 32'd2, 32'd3, 32'd3, 32'h0FF00FF0, 32'h000000F0, 32'h0F0F0F0F};
  logic [31:0] t_st[8] = '{32'hFFFFFFFE, 32'd3, 32'd1, 32'd3, 32'hFFFFFFFE, 32'hFF00FF00, 32'h0F0F00F0, 32'h0F000F00};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_reservation", {31'b0, reservation_valid}, 0);
    rst = 0;
    @(posedge clk);
    #1;
    // LR latency: mem req cycle 1, response cycle 2, writeback cycle 3
    rsp_val = 32'hDEADBEEF;
    push_m(0, 32'h1000, 0);
    push_w(8'd1, 32'hDEADBEEF);
    issue(32'h1000, 0, 0, AMO_ADD, 1, 8'd1);
    chk("lr_c1_mem_load", {31'b0, mem_req_valid && mem_req_load}, 1);
    @(posedge clk);
    #1;
    chk("lr_c2_waiting", {31'b0, busy && !mem_req_valid && !wb_valid}, 1);
    @(posedge clk);
    #1;
    chk("lr_c3_wb_valid", {31'b0, wb_valid}, 1);
    wait_done();
    chk("lr_reservation_set", {31'b0, reservation_valid}, 1);
    // SC success (low address bits ignored), then a second SC fails
    push_m(1, 32'h1000, 5);
    push_w(8'd2, 0);
    issue(32'h1002, 5, 1, AMO_ADD, 1, 8'd2);
    wait_done();
    chk("sc_clears_reservation", {31'b0, reservation_valid}, 0);
    push_w(8'd3, 1);
    issue(32'h1000, 6, 1, AMO_ADD, 1, 8'd3);
    wait_done();
    // snoop to a neighbouring word keeps the reservation, same word kills it
    rsp_val = 32'h12345678;
    push_m(0, 32'h2000, 0);
    push_w(8'd4, 32'h12345678);
    issue(32'h2000, 0, 0, AMO_ADD, 1, 8'd4);
    wait_done();
    snoop(32'h2004);
    chk("snoop_other_word", {31'b0, reservation_valid}, 1);
    snoop(32'h2000);
    chk("snoop_same_word", {31'b0, reservation_valid}, 0);
    push_w(8'd5, 1);
    issue(32'h2000, 9, 1, AMO_ADD, 1, 8'd5);
    wait_done();
    // read-modify-write ops: rd gets old value, memory gets f(old,rs2)
    for (int i = 0; i < 8; i++) begin
      rsp_val = t_old[i];
      push_m(0, 32'h3000 + 32'(i * 4), 0);
      push_m(1, 32'h3000 + 32'(i * 4), t_st[i]);
      push_w(8'(30 + i), t_old[i]);
      issue(32'h3000 + 32'(i * 4), t_rs2[i], 2, t_op[i], 1, 8'(30 + i));
      wait_done();
    end
    // reservation timeout 64 cycles after the LR response
    rsp_val = 32'h55;
    push_m(0, 32'h4000, 0);
    push_w(8'd7, 32'h55);
    issue(32'h4000, 0, 0, AMO_ADD, 1, 8'd7);
    @(posedge clk);
    #1;
    repeat (64) @(posedge clk);
    #1;
    chk("res_before_timeout", {31'b0, reservation_valid}, 1);
    @(posedge clk);
    #1;
    chk("res_timed_out", {31'b0, reservation_valid}, 0);
    wait_done();
    push_w(8'd8, 1);
    issue(32'h4000, 1, 1, AMO_ADD, 1, 8'd8);
    wait_done();
    // flush one cycle after the LR response clears the reservation
    rsp_val = 32'h66;
    push_m(0, 32'h5000, 0);
    push_w(8'd9, 32'h66);
    issue(32'h5000, 0, 0, AMO_ADD, 1, 8'd9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("res_before_flush", {31'b0, reservation_valid}, 1);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    chk("res_after_flush", {31'b0, reservation_valid}, 0);
    wait_done();
    push_w(8'd11, 1);
    issue(32'h5000, 2, 1, AMO_ADD, 1, 8'd11);
    wait_done();
    // AMOSWAP without writeback under a 5-cycle memory stall
    mem_ready = 0;
    rsp_val = 32'h77;
    push_m(0, 32'h6000, 0);
    push_m(1, 32'h6000, 32'hABCD);
    issue(32'h6000, 32'hABCD, 2, AMO_SWAP, 0, 8'd12);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_held", {31'b0, mem_req_valid && mem_req_load}, 1);
      chk("stall_addr_held", mem_req_addr, 32'h6000);
      @(posedge clk);
      #1;
    end
    mem_ready = 1;
    wait_done();
    chk("swap_nowb_idle", {31'b0, req_ready}, 1);
    // writeback held while wb_ack is low
    ack_en = 0;
    rsp_val = 32'h99;
    push_m(0, 32'h7000, 0);
    push_w(8'd20, 32'h99);
    issue(32'h7000, 0, 0, AMO_ADD, 1, 8'd20);
    for (int n = 0; n < 20 && !wb_valid; n++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_wb_valid", {31'b0, wb_valid}, 1);
      chk("hold_req_ready", {31'b0, req_ready}, 0);
      chk("hold_wb_data", wb_data, 32'h99);
      @(posedge clk);
      #1;
    end
    ack_en = 1;
    wait_done();
    chk("mem_queue_drained", 32'(mexp.size()), 0);
    chk("wb_queue_drained", 32'(wexp.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
